// File: rtl/id_issue_queue.sv
// id_issue_queue: FIFO between decode and issue that holds up to DEPTH decoded
// entries and caps the number of buffered control-flow entries at MAX_CF.
// Entries leave in strict FIFO order. Push and pop can happen on the same edge.
// flush_i empties the queue in one cycle. Reset is asynchronous and active-high.
// Optional build macro ID_ISSUE_QUEUE_BYPASS_EN: when the queue is empty, the
// incoming entry is forwarded combinationally to the issue side. If issue acks
// it in that cycle, the entry is consumed and never stored.
module id_issue_queue #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int MAX_CF     = 2,
  localparam int CNT_W     = $clog2(DEPTH + 1),
  localparam int CF_W      = $clog2(MAX_CF + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_ctrl_flow_i,
  output logic                  out_valid_o,
  input  logic                  out_ack_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_ctrl_flow_o,
  output logic [CNT_W-1:0]      count_o,
  output logic [CF_W-1:0]       cf_count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      cf_mem_q;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CF_W-1:0]       cf_cnt_q, cf_cnt_d;

  logic                  stored_valid;
  logic                  push, pop;
  logic                  wr_en, rd_en;
  logic                  bypass_take;
  logic                  cf_inc, cf_dec;

  // Pointer increment that wraps at DEPTH-1, valid for any DEPTH
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign stored_valid = (cnt_q != '0);

  // Head presentation: oldest stored entry, or the incoming entry when bypassing an empty queue
  always_comb begin
    out_valid_o     = stored_valid;
    out_data_o      = stored_valid ? mem_q[rd_ptr_q] : '0;
    out_ctrl_flow_o = stored_valid & cf_mem_q[rd_ptr_q];
`ifdef ID_ISSUE_QUEUE_BYPASS_EN
    if (!stored_valid && !flush_i && !rst_i) begin
      out_valid_o     = in_valid_i;
      out_data_o      = in_data_i;
      out_ctrl_flow_o = in_ctrl_flow_i;
    end
`endif
  end

  // Handshake: a pop frees a slot (and a control-flow credit) for a same-cycle push
  always_comb begin
    pop        = out_valid_o & out_ack_i & ~flush_i;
    in_ready_o = ~flush_i
               & ((cnt_q < CNT_W'(DEPTH)) | pop)
               & (~in_ctrl_flow_i | (cf_cnt_q < CF_W'(MAX_CF)) | (pop & out_ctrl_flow_o));
    push        = in_valid_i & in_ready_o;
    // Only reachable with bypass: the entry is consumed straight from the input
    bypass_take = push & pop & ~stored_valid;
    wr_en       = push & ~bypass_take;
    rd_en       = pop & stored_valid;
    cf_inc      = wr_en & in_ctrl_flow_i;
    cf_dec      = rd_en & cf_mem_q[rd_ptr_q];
  end

  // Next-state for pointers and occupancy counters
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    cf_cnt_d = cf_cnt_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
      cf_cnt_d = '0;
    end else begin
      if (rd_en) begin
        rd_ptr_d = ptr_next(rd_ptr_q);
      end
      if (wr_en) begin
        wr_ptr_d = ptr_next(wr_ptr_q);
      end
      if (wr_en && !rd_en) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (!wr_en && rd_en) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      if (cf_inc && !cf_dec) begin
        cf_cnt_d = cf_cnt_q + CF_W'(1);
      end else if (!cf_inc && cf_dec) begin
        cf_cnt_d = cf_cnt_q - CF_W'(1);
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      cf_cnt_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      cf_cnt_q <= cf_cnt_d;
    end
  end

  // Entry storage: payload and control-flow flag are written together at the tail
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      cf_mem_q <= '0;
    end else if (wr_en && !flush_i) begin
      mem_q[wr_ptr_q]    <= in_data_i;
      cf_mem_q[wr_ptr_q] <= in_ctrl_flow_i;
    end
  end

  assign count_o    = cnt_q;
  assign cf_count_o = cf_cnt_q;

endmodule

// File: tb/tb_id_issue_queue.sv
// Bench for id_issue_queue: a queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations (DEPTH=4 and DEPTH=3 instances).
module tb_id_issue_queue;

  localparam int DW = 64;
  localparam int DEPTH = 4;
  localparam int MAX_CF = 2;
`ifdef ID_ISSUE_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0, in_valid = 1'b0, in_cf = 1'b0, ack = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid, out_cf;
  logic [DW-1:0] out_data;
  logic [2:0]    count;
  logic [1:0]    cf_count;

  logic          v3 = 1'b0, a3 = 1'b0;
  logic [DW-1:0] d3 = '0;
  logic          rdy3, ov3, ocf3;
  logic [DW-1:0] od3;
  logic [1:0]    cnt3, cfc3;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  id_issue_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_CF(MAX_CF)) u_dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .in_ctrl_flow_i(in_cf), .out_valid_o(out_valid), .out_ack_i(ack),
    .out_data_o(out_data), .out_ctrl_flow_o(out_cf),
    .count_o(count), .cf_count_o(cf_count)
  );

  id_issue_queue #(.DATA_WIDTH(DW), .DEPTH(3), .MAX_CF(2)) u_d3 (
    .clk_i(clk), .rst_i(rst), .flush_i(1'b0),
    .in_valid_i(v3), .in_ready_o(rdy3), .in_data_i(d3),
    .in_ctrl_flow_i(1'b0), .out_valid_o(ov3), .out_ack_i(a3),
    .out_data_o(od3), .out_ctrl_flow_o(ocf3),
    .count_o(cnt3), .cf_count_o(cfc3)
  );

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic cf; logic [DW-1:0] d; } ent_t;
  ent_t mq[$];

  function automatic int m_cfn();
    int c = 0;
    foreach (mq[i]) if (mq[i].cf) c++;
    return c;
  endfunction

  function automatic bit m_valid();
    return (mq.size() > 0) || (BYP && !rst && !flush && in_valid);
  endfunction

  function automatic ent_t m_head();
    ent_t e;
    if (mq.size() > 0) e = mq[0];
    else begin e.cf = in_cf; e.d = in_data; end
    return e;
  endfunction

  function automatic bit m_pop();
    return m_valid() && ack && !flush;
  endfunction

  function automatic bit m_ready();
    ent_t h = m_head();
    bit p = m_pop();
    return !flush && (mq.size() < DEPTH || p) &&
           (!in_cf || m_cfn() < MAX_CF || (p && h.cf));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      mq.delete();
    end else begin
      automatic int  n   = mq.size();
      automatic bit  p   = m_pop();
      automatic bit  psh = in_valid && m_ready();
      automatic ent_t e;
      e.cf = in_cf;
      e.d  = in_data;
      if (p && n > 0) void'(mq.pop_front());
      if (psh && !(p && n == 0)) mq.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      automatic ent_t h = m_head();
      chk("m_count", DW'(count), DW'(mq.size()));
      chk("m_cf_count", DW'(cf_count), DW'(m_cfn()));
      chk("m_out_valid", DW'(out_valid), DW'(m_valid()));
      chk("m_in_ready", DW'(in_ready), DW'(m_ready()));
      if (m_valid()) begin
        chk("m_out_data", out_data, h.d);
        chk("m_out_cf", DW'(out_cf), DW'(h.cf));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic v, input logic [DW-1:0] d, input logic c,
                     input logic a, input logic f);
    in_valid = v; in_data = d; in_cf = c; ack = a; flush = f;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] drain_exp [4];
    int k;
    drain_exp[0] = 'h22; drain_exp[1] = 'h33; drain_exp[2] = 'h44; drain_exp[3] = 'h55;
    chk_en = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_count", DW'(count), 0);
    chk("rst_cf_count", DW'(cf_count), 0);
    chk("rst_out_valid", DW'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_cf", DW'(out_cf), 0);
    chk("rst_in_ready", DW'(in_ready), 1);
    @(posedge clk); #1 rst = 1'b0;

    // fill to DEPTH
    for (int i = 0; i < 4; i++) begin
      set(1'b1, DW'((i + 1) * 'h11), 1'b0, 1'b0, 1'b0);
      cyc();
    end
    set(1'b1, 'h55, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_count", DW'(count), 4);
    chk("full_in_ready", DW'(in_ready), 0);
    chk("full_head", out_data, 'h11);
    cyc();

    // full with simultaneous push and pop
    set(1'b1, 'h55, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("fullpop_in_ready", DW'(in_ready), 1);
    cyc();
    set(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("fullpop_count", DW'(count), 4);
    chk("fullpop_head", out_data, 'h22);
    cyc();
    for (int i = 0; i < 4; i++) begin
      set(1'b0, '0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("drain_order", out_data, drain_exp[i]);
      cyc();
    end
    set(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("drain_count", DW'(count), 0);
    cyc();

    // control-flow credit limit
    set(1'b1, 'hC1, 1'b1, 1'b0, 1'b0); cyc();
    set(1'b1, 'hC2, 1'b1, 1'b0, 1'b0); cyc();
    set(1'b1, 'hC3, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("cf_block_ready", DW'(in_ready), 0);
    chk("cf_block_cnt", DW'(cf_count), 2);
    cyc();
    set(1'b1, 'hD1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("cf_plain_ready", DW'(in_ready), 1);
    cyc();
    set(1'b1, 'hC3, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("cf_pop_ready", DW'(in_ready), 1);
    cyc();
    set(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("cf_after_cnt", DW'(cf_count), 2);
    chk("cf_after_count", DW'(count), 3);
    chk("cf_after_head", out_data, 'hC2);
    cyc();

    // flush with push and ack offered
    set(1'b1, 'hEE, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("flush_in_ready", DW'(in_ready), 0);
    cyc();
    set(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush_count", DW'(count), 0);
    chk("flush_cf_count", DW'(cf_count), 0);
    chk("flush_out_valid", DW'(out_valid), 0);
    cyc();
    set(1'b1, 'hE1, 1'b0, 1'b0, 1'b0); cyc();
    set(1'b0, '0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("post_flush_head", out_data, 'hE1);
    cyc();
    set(1'b0, '0, 1'b0, 1'b0, 1'b0); cyc();

    // empty queue, push with ack in the same cycle
    set(1'b1, 'hAA, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
`ifdef ID_ISSUE_QUEUE_BYPASS_EN
    chk("byp_out_valid", DW'(out_valid), 1);
    chk("byp_out_data", out_data, 'hAA);
`else
    chk("nobyp_out_valid", DW'(out_valid), 0);
`endif
    cyc();
    set(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
`ifdef ID_ISSUE_QUEUE_BYPASS_EN
    chk("byp_count", DW'(count), 0);
`else
    chk("nobyp_count", DW'(count), 1);
    chk("nobyp_out_data", out_data, 'hAA);
`endif
    cyc();
    set(1'b0, '0, 1'b0, 1'b1, 1'b0); cyc();
    set(1'b0, '0, 1'b0, 1'b0, 1'b0); cyc();

    // asynchronous reset mid-operation
    set(1'b1, 'h71, 1'b0, 1'b0, 1'b0); cyc();
    set(1'b1, 'h72, 1'b1, 1'b0, 1'b0); cyc();
    set(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", DW'(count), 0);
    chk("arst_cf_count", DW'(cf_count), 0);
    chk("arst_out_valid", DW'(out_valid), 0);
    @(posedge clk); #1 rst = 1'b0;

    // mixed traffic pattern, checked by the model
    for (int i = 0; i < 40; i++) begin
      set((i % 3) != 0, DW'('h100 + i), (i % 5) == 0, (i % 2) == 1 || (i % 7) == 0, i == 25);
      cyc();
    end
    for (int i = 0; i < 6; i++) begin
      set(1'b0, '0, 1'b0, 1'b1, 1'b0);
      cyc();
    end
    set(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("mix_drained", DW'(count), 0);
    cyc();

    // DEPTH=3 instance: ordering across pointer wrap
    k = 0;
    for (int i = 0; i < 3; i++) begin
      v3 = 1'b1; d3 = DW'(i); a3 = 1'b0;
      cyc();
    end
    for (int i = 3; i < 10; i++) begin
      v3 = 1'b1; d3 = DW'(i); a3 = 1'b1;
      @(negedge clk);
      chk("d3_ready", DW'(rdy3), 1);
      chk("d3_count", DW'(cnt3), 3);
      if (ov3) begin
        chk("d3_order", od3, DW'(k));
        k++;
      end
      cyc();
    end
    for (int i = 0; i < 6; i++) begin
      v3 = 1'b0; d3 = '0; a3 = 1'b1;
      @(negedge clk);
      if (ov3) begin
        chk("d3_order", od3, DW'(k));
        k++;
      end
      cyc();
    end
    a3 = 1'b0;
    chk("d3_total", DW'(k), 10);
    chk("d3_empty", DW'(cnt3), 0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_issue_queue.md
ID_ISSUE_QUEUE -- requirements
Module: id_issue_queue

Interface
REQ-001 Parameter DATA_WIDTH, default 64: width of one decoded-instruction payload.
REQ-002 Parameter DEPTH, default 4: number of buffered entries; legal range 2..16, any integer.
REQ-003 Parameter MAX_CF, default 2: max control-flow entries held at once; legal range 1..DEPTH.
REQ-004 clk_i  input  1  clock; all state on rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 flush_i  input  1  discard all buffered entries.
REQ-007 in_valid_i  input  1  decode presents an entry.
REQ-008 in_ready_o  output  1  queue accepts entry this cycle.
REQ-009 in_data_i  input  DATA_WIDTH  entry payload.
REQ-010 in_ctrl_flow_i  input  1  entry is a control-flow instruction.
REQ-011 out_valid_o  output  1  head entry valid toward issue.
REQ-012 out_ack_i  input  1  issue samples head entry; ignored when out_valid_o=0.
REQ-013 out_data_o  output  DATA_WIDTH  head payload.
REQ-014 out_ctrl_flow_o  output  1  head control-flow flag.
REQ-015 count_o  output  clog2(DEPTH+1)  entries stored.
REQ-016 cf_count_o  output  clog2(MAX_CF+1)  control-flow entries stored.

Function
REQ-017 push = in_valid_i & in_ready_o; pop = out_valid_o & out_ack_i; both SHALL take effect at the same rising edge.
REQ-018 in_ready_o SHALL be 1 iff flush_i=0 and (count_o<DEPTH or pop) and (in_ctrl_flow_i=0 or cf_count_o<MAX_CF or pop of a control-flow head).
REQ-019 Entries SHALL leave in strict FIFO order; payload and ctrl-flow flag travel together unmodified.
REQ-020 Without bypass, out_valid_o=1 iff count_o>0; out_data_o/out_ctrl_flow_o SHALL show the oldest entry; enqueue-to-visible latency 1 cycle.
REQ-021 Full (count_o=DEPTH) with simultaneous pop: push accepted, count unchanged.
REQ-022 Empty with push: count becomes 1 next cycle; no pop possible the same cycle (non-bypass).
REQ-023 count_o SHALL update by +1 (push only), -1 (pop only), 0 (both/neither); cf_count_o likewise using the ctrl-flow flag of pushed/popped entries.
REQ-024 Read/write pointers SHALL wrap from DEPTH-1 to 0, correct for non-power-of-two DEPTH.
REQ-025 flush_i=1: push suppressed (in_ready_o=0), any pop ignored, next cycle count_o=0, cf_count_o=0, out_valid_o=0; pointers return to 0.
REQ-026 out_data_o SHALL be stable while out_valid_o=1 and out_ack_i=0.

Reset
REQ-027 While rst_i=1: count_o=0, cf_count_o=0, out_valid_o=0, out_data_o=0, out_ctrl_flow_o=0, pointers=0, storage=0; in_ready_o follows REQ-018 with zero counts.
REQ-028 Reset asserted mid-operation SHALL discard all entries immediately, independent of clk_i.

Configuration
REQ-029 Macro ID_ISSUE_QUEUE_BYPASS_EN defined: when count_o=0 and flush_i=0, out_valid_o=in_valid_i and out_data_o/out_ctrl_flow_o=in_data_i/in_ctrl_flow_i combinationally; if out_ack_i=1 that cycle the entry is consumed and not stored, counts unchanged.
REQ-030 Macro undefined: no combinational path in_*->out_*; REQ-020 latency applies.

Verification
REQ-031 Reset, then 4 pushes (data 0x11..0x44, no ack) -> count_o=4, in_ready_o=0, out_data_o=0x11.
REQ-032 Full queue, push 0x55 with out_ack_i=1 same cycle -> next cycle count_o=4, out_data_o=0x22, 0x55 last out.
REQ-033 MAX_CF=2, push 2 ctrl-flow entries, offer 3rd ctrl-flow -> in_ready_o=0; offer non-ctrl-flow -> in_ready_o=1, cf_count_o stays 2.
REQ-034 3 entries stored, flush_i=1 with in_valid_i=1 and out_ack_i=1 -> next cycle count_o=0, out_valid_o=0, nothing enqueued.
REQ-035 DEPTH=3, 10 push/pop cycles with incrementing data -> output order 0..9, pointer wrap without loss.
REQ-036 Bypass build, empty queue, push 0xAA with out_ack_i=1 -> out_valid_o=1, out_data_o=0xAA same cycle, count_o stays 0; non-bypass build -> 0xAA appears next cycle.
